fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The parameter RESET_PC SHALL default to 64'h0 and SHALL be the first fetch address after reset.
REQ-002 The parameter HALT_INSTR SHALL default to 32'hD4400000 and SHALL be the encoding that stops fetch.
REQ-003 The port clock SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide: the reset, synchronous and active-high.
REQ-005 The port stall SHALL be an input, 1 bit wide: load-use hold from the hazard unit.
REQ-006 The port flush SHALL be an input, 1 bit wide: taken-branch redirect from the MEM stage.
REQ-007 The port branch_target SHALL be an input, 64 bits wide: the redirect address, valid when flush=1.
REQ-008 The port imem_instr SHALL be an input, 32 bits wide: combinational instruction-memory read data for imem_addr.
REQ-009 The port imem_addr SHALL be an output, 64 bits wide: the current fetch PC, driven combinationally from the PC register.
REQ-010 The port pc SHALL be an output, 64 bits wide: the IF/ID latched PC, feeding pc on id_ex.
REQ-011 The port instruction SHALL be an output, 32 bits wide: the IF/ID latched instruction, feeding decode and id_ex.
REQ-012 The port valid SHALL be an output, 1 bit wide: the IF/ID slot holds a real instruction.
REQ-013 The port halted SHALL be an output, 1 bit wide: the FSM is in HALTED.

Function
REQ-014 The block SHALL implement a two-state FSM with states RUN and HALTED.
REQ-015 The next-state priority SHALL be reset > flush > stall > HALTED hold > normal fetch.
REQ-016 On flush, the block SHALL set fetch_pc to {branch_target[63:2],2'b00}, set instruction=0, pc=0, valid=0, and set state=RUN (a flush exits HALTED).
REQ-017 On stall without flush, the block SHALL hold fetch_pc, pc, instruction, valid and state unchanged.
REQ-018 On a normal RUN cycle, the block SHALL set pc=fetch_pc, instruction=imem_instr, valid=1 and fetch_pc=fetch_pc+4.
REQ-019 When imem_instr==HALT_INSTR on a normal RUN cycle, the block SHALL latch it with valid=1, hold fetch_pc (no increment), and set state=HALTED.
REQ-020 In HALTED without flush or stall, the block SHALL set valid=0, instruction=0, pc=0 and hold fetch_pc.
REQ-021 Increments of fetch_pc SHALL wrap modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC+4 yields 0 with no error.
REQ-022 Latency from imem_instr to the instruction output SHALL be exactly 1 cycle; flush-to-first-target-instruction SHALL be exactly 1 cycle.
REQ-023 Simultaneous flush and stall SHALL behave as flush alone.
REQ-024 The halted output SHALL be 1 exactly when state==HALTED, registered.

Reset
REQ-025 On reset, the block SHALL set fetch_pc=RESET_PC, pc=0, instruction=0, valid=0, state=RUN and halted=0 on the next clock edge.
REQ-026 Reset asserted mid-stall, mid-flush or in HALTED SHALL override all inputs in that cycle.
REQ-027 With reset held, imem_addr SHALL equal RESET_PC from the first edge onward.

Configuration
REQ-028 With FETCH_PERF_EN defined, the block SHALL add outputs fetch_count[31:0] and flush_count[31:0].
REQ-029 fetch_count SHALL increment on each normal RUN latch with valid=1, including the halt instruction.
REQ-030 flush_count SHALL increment on each flush cycle.
REQ-031 Both counters SHALL wrap at 2^32 and clear on reset.
REQ-032 Without FETCH_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package legv8_pkg SHALL hold PC_WIDTH=64, INSTR_WIDTH=32, PC_STEP=4, the HALT encoding constant and the fetch FSM state typedef.
REQ-034 One sub-module, pc_register, SHALL hold fetch_pc with load/hold/increment controls; the IF/ID latch and FSM SHALL stay in fetch_stage.

Verification
REQ-035 Reset then release, with imem returning 32'h8B020020 at 0 and 32'hCB030041 at 4 -> the first instruction output is 32'h8B020020 with pc=0 and valid=1, then pc=4; imem_addr reads 0,4,8.
REQ-036 Stall held 3 cycles at fetch_pc=0x10 -> imem_addr stays 0x10 and the IF/ID outputs are frozen for 3 cycles; the PC resumes at 0x14.
REQ-037 flush=1 and stall=1 with branch_target=0x203 -> next imem_addr=0x200 and valid=0; the following cycle latches instruction from 0x200.
REQ-038 RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> imem_addr sequence ...FF8, ...FFC, 0x0.
REQ-039 Fetch HALT_INSTR at 0x40 -> it is latched with valid=1; then halted=1, valid=0 and imem_addr=0x40 steady; flush to 0x80 resumes RUN; reset in HALTED returns to RESET_PC.
REQ-040 With FETCH_PERF_EN defined, 5 fetches plus 2 flushes -> fetch_count=5 and flush_count=2; reset -> both 0.

Source files
------------

// File: rtl/legv8_pkg.sv
// legv8_pkg: constants and types shared by the LEGv8 fetch logic.
//   PC_WIDTH / INSTR_WIDTH : datapath widths
//   PC_STEP                : sequential fetch increment
//   PC_ALIGN_MASK          : low PC bits forced to zero on a redirect
//   HALT_ENC               : default encoding that stops fetch
//   fetch_state_t          : fetch FSM states
package legv8_pkg;

    localparam int unsigned PC_WIDTH    = 64;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0]    PC_STEP       = 64'd4;
    localparam logic [PC_WIDTH-1:0]    PC_ALIGN_MASK = 64'd3;
    localparam logic [INSTR_WIDTH-1:0] HALT_ENC      = 32'hD440_0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// pc_register: holds the fetch PC.
//   Parameter RESET_PC : value loaded on reset.
//   clock        : rising-edge clock
//   reset        : synchronous, active-high; loads RESET_PC
//   i_load       : load i_load_value (wins over i_inc)
//   i_load_value : address to load
//   i_inc        : advance by PC_STEP, wrapping modulo 2^64
//   o_pc         : current fetch PC
module pc_register
    import legv8_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_load,
    input  logic [PC_WIDTH-1:0] i_load_value,
    input  logic                i_inc,
    output logic [PC_WIDTH-1:0] o_pc
);

    logic [PC_WIDTH-1:0] r_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_value;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction fetch with IF/ID latch and RUN/HALTED FSM.
//   Parameters : RESET_PC (first fetch address), HALT_INSTR (stops fetch)
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   stall          : hold everything (load-use hazard)
//   flush          : redirect to branch_target, kill IF/ID slot, leave HALTED
//   branch_target  : redirect address, low two bits ignored
//   imem_instr     : combinational instruction memory data for imem_addr
//   imem_addr      : current fetch PC
//   pc, instruction, valid : IF/ID latch contents
//   halted         : FSM is in HALTED
// Optional macro FETCH_PERF_EN adds fetch_count / flush_count (32-bit, wrapping).
module fetch_stage
    import legv8_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = 64'h0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = HALT_ENC
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   valid,
    output logic                   halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            flush_count
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_valid;

    logic [PC_WIDTH-1:0]    w_pc_next;
    logic [INSTR_WIDTH-1:0] w_instr_next;
    logic                   w_valid_next;

    logic                   w_pc_load;
    logic                   w_pc_inc;
    logic [PC_WIDTH-1:0]    w_fetch_pc;
    logic [PC_WIDTH-1:0]    w_target;

    assign w_target = branch_target & ~PC_ALIGN_MASK;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_pc_load),
        .i_load_value (w_target),
        .i_inc        (w_pc_inc),
        .o_pc         (w_fetch_pc)
    );

    // Priority: flush > stall > HALTED hold > normal fetch (reset is in the registers).
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_valid_next = r_valid;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;

        if (flush) begin
            w_next_state = ST_RUN;
            w_pc_next    = '0;
            w_instr_next = '0;
            w_valid_next = 1'b0;
            w_pc_load    = 1'b1;
        end else if (!stall) begin
            if (r_state == ST_HALTED) begin
                w_pc_next    = '0;
                w_instr_next = '0;
                w_valid_next = 1'b0;
            end else begin
                w_pc_next    = w_fetch_pc;
                w_instr_next = imem_instr;
                w_valid_next = 1'b1;
                // The halt instruction is delivered but the PC parks on it.
                if (imem_instr == HALT_INSTR) begin
                    w_next_state = ST_HALTED;
                end else begin
                    w_pc_inc = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
        end
    end

    assign imem_addr   = w_fetch_pc;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign valid       = r_valid;
    assign halted      = (r_state == ST_HALTED);

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;
    logic        w_fetch_evt;

    assign w_fetch_evt = !flush && !stall && (r_state == ST_RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_fetch_evt) r_fetch_count <= r_fetch_count + 32'd1;
            if (flush)       r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A behavioural model of
// the fetch rules predicts each cycle's outputs; a monitor compares them.
// A second instance with a near-top RESET_PC exercises address wrap.
module tb_fetch_stage;
    import legv8_pkg::*;

    localparam logic [63:0] W_RESET = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] NO_HALT = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1, stall = 1'b0, flush = 1'b0;
    logic [63:0] branch_target = '0;
    logic [63:0] halt_addr = 64'h40;

    logic [31:0] imem_instr, w2_imem_instr;
    logic [63:0] imem_addr, pc, w2_addr, w2_pc;
    logic [31:0] instruction, w2_instr;
    logic        valid, halted, w2_valid, w2_halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, flush_count, w2_fcount, w2_flcount;
`endif

    // Instruction memory contents: fixed words at 0 and 4, halt at halt address,
    // otherwise an odd hash (never equal to the even halt encoding).
    function automatic logic [31:0] mem_fn(input logic [63:0] a, input logic [63:0] ha);
        if (a == ha)       return HALT_ENC;
        if (a == 64'h0)    return 32'h8B02_0020;
        if (a == 64'h4)    return 32'hCB03_0041;
        return ((a[31:0] * 32'h9E37_79B1) ^ a[63:32]) | 32'h1;
    endfunction

    assign imem_instr    = mem_fn(imem_addr, halt_addr);
    assign w2_imem_instr = mem_fn(w2_addr, NO_HALT);

    fetch_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .branch_target(branch_target), .imem_instr(imem_instr),
        .imem_addr(imem_addr), .pc(pc), .instruction(instruction),
        .valid(valid), .halted(halted)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    fetch_stage #(.RESET_PC(W_RESET)) dut_wrap (
        .clock(clock), .reset(reset), .stall(1'b0), .flush(1'b0),
        .branch_target(64'h0), .imem_instr(w2_imem_instr),
        .imem_addr(w2_addr), .pc(w2_pc), .instruction(w2_instr),
        .valid(w2_valid), .halted(w2_halted)
`ifdef FETCH_PERF_EN
        , .fetch_count(w2_fcount), .flush_count(w2_flcount)
`endif
    );

    typedef struct {
        logic [63:0] fpc, pc;
        logic [31:0] instr;
        logic        valid, halted;
        logic [31:0] fc, flc;
        logic [63:0] wfpc, wpc;
        logic [31:0] winstr;
        logic        wvalid;
        logic [31:0] wfc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Model state: architectural view of the fetch unit.
    logic [63:0] m_fpc, m_pc, m_wfpc, m_wpc;
    logic [31:0] m_instr, m_fc, m_flc, m_winstr, m_wfc;
    logic        m_valid, m_halted, m_wvalid;

    task automatic step(input logic rst, input logic stl, input logic fl, input logic [63:0] bt);
        exp_t        e;
        logic [31:0] word;
        reset = rst; stall = stl; flush = fl; branch_target = bt;
        if (rst) begin
            m_fpc = W_RESET - W_RESET; m_pc = '0; m_instr = '0; m_valid = 1'b0;
            m_halted = 1'b0; m_fc = '0; m_flc = '0;
        end else if (fl) begin
            m_fpc = (bt / 4) * 4; m_pc = '0; m_instr = '0; m_valid = 1'b0;
            m_halted = 1'b0; m_flc = m_flc + 1;
        end else if (stl) begin
            // everything holds
        end else if (m_halted) begin
            m_pc = '0; m_instr = '0; m_valid = 1'b0;
        end else begin
            word = mem_fn(m_fpc, halt_addr);
            m_pc = m_fpc; m_instr = word; m_valid = 1'b1; m_fc = m_fc + 1;
            if (word == HALT_ENC) m_halted = 1'b1;
            else                  m_fpc = m_fpc + 64'd4;
        end
        if (rst) begin
            m_wfpc = W_RESET; m_wpc = '0; m_winstr = '0; m_wvalid = 1'b0; m_wfc = '0;
        end else begin
            m_wpc = m_wfpc; m_winstr = mem_fn(m_wfpc, NO_HALT); m_wvalid = 1'b1;
            m_wfc = m_wfc + 1; m_wfpc = m_wfpc + 64'd4;
        end
        e.fpc = m_fpc; e.pc = m_pc; e.instr = m_instr; e.valid = m_valid;
        e.halted = m_halted; e.fc = m_fc; e.flc = m_flc;
        e.wfpc = m_wfpc; e.wpc = m_wpc; e.winstr = m_winstr; e.wvalid = m_wvalid;
        e.wfc = m_wfc;
        q.push_back(e);
        @(negedge clock);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: outputs settle just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("imem_addr",   imem_addr,            e.fpc);
                chk("pc",          pc,                   e.pc);
                chk("instruction", {32'h0, instruction}, {32'h0, e.instr});
                chk("valid",       {63'h0, valid},       {63'h0, e.valid});
                chk("halted",      {63'h0, halted},      {63'h0, e.halted});
                chk("wrap_addr",   w2_addr,              e.wfpc);
                chk("wrap_pc",     w2_pc,                e.wpc);
                chk("wrap_instr",  {32'h0, w2_instr},    {32'h0, e.winstr});
                chk("wrap_valid",  {63'h0, w2_valid},    {63'h0, e.wvalid});
                chk("wrap_halted", {63'h0, w2_halted},   64'h0);
`ifdef FETCH_PERF_EN
                chk("fetch_count", {32'h0, fetch_count}, {32'h0, e.fc});
                chk("flush_count", {32'h0, flush_count}, {32'h0, e.flc});
                chk("wrap_fcount", {32'h0, w2_fcount},   {32'h0, e.wfc});
                chk("wrap_flcount",{32'h0, w2_flcount},  64'h0);
`endif
            end
        end
    end

    initial begin
        int waited;
        @(negedge clock);
        // Reset, then straight-line fetch from 0.
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        // Stall three cycles at 0x10, then resume.
        repeat (3) step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        // Flush with stall, unaligned target.
        step(0, 1, 1, 64'h203);
        repeat (2) step(0, 0, 0, 0);
        // Run into the halt at 0x40, sit halted, flush out to 0x80.
        step(0, 0, 1, 64'h38);
        repeat (6) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 64'h80);
        repeat (2) step(0, 0, 0, 0);
        // Halt again, then reset while halted.
        step(0, 0, 1, 64'h3C);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        // Five fetches plus two flushes for the counters.
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 1, 64'h100); step(0, 0, 1, 64'h200);
        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic        r, s, f;
            logic [63:0] bt;
            r = ($urandom % 60) == 0;
            f = ($urandom % 8) == 0;
            s = ($urandom % 5) == 0;
            if (($urandom % 4) == 0) bt = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
            else                     bt = 64'($urandom_range(0, 127));
            step(r, s, f, bt);
        end
        step(0, 0, 0, 0);
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
